vacc_cmd_queue: RTL and testbench

Parametrised command front-end for the video accelerator: accepts 64-bit data-mover commands as pairs of 32-bit register writes and buffers them in N_QUEUE independent FIFOs. Each FIFO presents a valid/ready command port to one data mover (stream reader or stream writer) and collects per-queue completion counts and sticky error status. It replaces the fixed two-FIFO, toggle-paired register logic with explicit low/high word addressing, flush, overflow detection, completion counting and an optional interrupt.

---
 rtl/vacc_cmd_queue.sv | 202 ++++++++++++++++++++
 tb/tb_vacc_cmd_queue.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vacc_cmd_queue.sv
// vacc_cmd_queue: register-fed 64-bit command FIFOs feeding the data movers.
// Define VACC_CMD_IRQ_EN to build the completion interrupt and irq_mask bits.
module vacc_cmd_queue #(
    parameter int N_QUEUE        = 2,
    parameter int DEPTH_LOG2     = 7,
    parameter int DEST_MAX       = 3,
    parameter int REG_ADDR_WIDTH = 12
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      reg_en,
    input  logic [3:0]                reg_we,
    input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
    input  logic [31:0]               reg_wdata,
    output logic [31:0]               reg_rdata,
    output logic [64*N_QUEUE-1:0]     cmd_data,
    output logic [N_QUEUE-1:0]        cmd_valid,
    input  logic [N_QUEUE-1:0]        cmd_ready,
    input  logic [N_QUEUE-1:0]        done,
    output logic                      irq
);

    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [2:0]  addr_q;
    logic [1:0]  addr_off;
    logic        addr_hit;
    logic        wr_any;
    logic        unused_addr;

    assign addr_q      = reg_addr[6:4];
    assign addr_off    = reg_addr[3:2];
    assign addr_hit    = (reg_addr[REG_ADDR_WIDTH-1:7] == '0) &&
                         (int'(addr_q) < N_QUEUE);
    assign wr_any      = reg_en && (reg_we == 4'b1111) && addr_hit;
    assign unused_addr = ^reg_addr[1:0];

    logic [CW-1:0]      occ  [N_QUEUE];
    logic [15:0]        dcnt [N_QUEUE];
    logic [N_QUEUE-1:0] lv;
    logic [N_QUEUE-1:0] err;
    logic [N_QUEUE-1:0] full;
    logic [N_QUEUE-1:0] empty;
    logic [N_QUEUE-1:0] mask;

    for (genvar g = 0; g < N_QUEUE; g++) begin : g_q
        logic [63:0]           mem [2**DEPTH_LOG2];
        logic [DEPTH_LOG2-1:0] wptr;
        logic [DEPTH_LOG2-1:0] rptr;
        logic [CW-1:0]         cnt;
        logic [31:0]           low;
        logic                  low_v;
        logic                  err_r;
        logic [15:0]           dc;
        logic                  sel;
        logic                  wr_lo;
        logic                  wr_hi;
        logic                  wr_clr;
        logic                  wr_ctl;
        logic                  flush;
        logic                  push;
        logic                  pop;
        logic                  is_full;
        logic                  is_empty;
        logic [63:0]           head;

        assign sel      = wr_any && (addr_q == 3'(g));
        assign wr_lo    = sel && (addr_off == 2'd0);
        assign wr_hi    = sel && (addr_off == 2'd1);
        assign wr_clr   = sel && (addr_off == 2'd2);
        assign wr_ctl   = sel && (addr_off == 2'd3);
        assign flush    = wr_ctl && reg_wdata[0];
        assign is_full  = (cnt == FULL_CNT);
        assign is_empty = (cnt == '0);
        // Full is judged on the pre-pop count, so a pop never makes room.
        assign pop      = !is_empty && cmd_ready[g];
        assign push     = wr_hi && low_v && !is_full && !flush;

        always_ff @(posedge aclk) begin
            if (push) begin
                mem[wptr] <= {reg_wdata, low};
            end
        end

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                wptr  <= '0;
                rptr  <= '0;
                cnt   <= '0;
                low   <= '0;
                low_v <= 1'b0;
                err_r <= 1'b0;
                dc    <= '0;
            end else begin
                if (flush) begin
                    wptr <= '0;
                    rptr <= '0;
                    cnt  <= '0;
                end else begin
                    if (push) begin
                        wptr <= wptr + 1'b1;
                    end
                    if (pop) begin
                        rptr <= rptr + 1'b1;
                    end
                    cnt <= cnt + CW'(push) - CW'(pop);
                end
                if (wr_lo) begin
                    low   <= reg_wdata;
                    low_v <= 1'b1;
                end else if (wr_hi || flush) begin
                    low_v <= 1'b0;
                end
                if (wr_hi && !push) begin
                    err_r <= 1'b1;
                end else if (wr_ctl && reg_wdata[1]) begin
                    err_r <= 1'b0;
                end
                // A clear that coincides with done keeps that completion.
                if (wr_clr) begin
                    dc <= {15'b0, done[g]};
                end else if (done[g] && (dc != 16'hFFFF)) begin
                    dc <= dc + 16'd1;
                end
            end
        end

`ifdef VACC_CMD_IRQ_EN
        logic mask_r;

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                mask_r <= 1'b0;
            end else if (wr_ctl) begin
                mask_r <= reg_wdata[4];
            end
        end

        assign mask[g] = mask_r;
`else
        assign mask[g] = 1'b0;
`endif

        assign head = is_empty ? 64'd0 : mem[rptr];

        assign cmd_data[64*g +: 64] = (int'(head[2:0]) > DEST_MAX) ?
                                      {head[63:3], 3'b000} : head;
        assign cmd_valid[g] = !is_empty;

        assign occ[g]   = cnt;
        assign dcnt[g]  = dc;
        assign lv[g]    = low_v;
        assign err[g]   = err_r;
        assign full[g]  = is_full;
        assign empty[g] = is_empty;
    end

    logic [31:0] rd_val;

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < N_QUEUE; i++) begin
            if (addr_hit && (addr_q == 3'(i))) begin
                case (addr_off)
                    2'd0:    rd_val = 32'(occ[i]);
                    2'd1:    rd_val = 32'(FULL_CNT - occ[i]);
                    2'd2:    rd_val = {16'b0, dcnt[i]};
                    default: rd_val = {27'b0, mask[i], lv[i],
                                       err[i], full[i], empty[i]};
                endcase
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            reg_rdata <= '0;
        end else if (reg_en) begin
            reg_rdata <= rd_val;
        end
    end

`ifdef VACC_CMD_IRQ_EN
    logic [N_QUEUE-1:0] pend;

    for (genvar g = 0; g < N_QUEUE; g++) begin : g_pend
        assign pend[g] = mask[g] && (dcnt[g] != 16'd0);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            irq <= 1'b0;
        end else begin
            irq <= |pend;
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_vacc_cmd_queue.sv
// tb_vacc_cmd_queue: random + directed bench for vacc_cmd_queue.
// Checks every cycle against a queue-level model of the register block.
module tb_vacc_cmd_queue;

    localparam int NQ    = 2;
    localparam int DEPTH = 128;
    localparam int DMAX  = 3;
    localparam int AW    = 12;
`ifdef VACC_CMD_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic            reg_en = 1'b0;
    logic [3:0]      reg_we = '0;
    logic [AW-1:0]   reg_addr = '0;
    logic [31:0]     reg_wdata = '0;
    logic [31:0]     reg_rdata;
    logic [64*NQ-1:0] cmd_data;
    logic [NQ-1:0]   cmd_valid;
    logic [NQ-1:0]   cmd_ready = '0;
    logic [NQ-1:0]   done = '0;
    logic            irq;

    int n_chk = 0;
    int n_fail = 0;

    vacc_cmd_queue #(
        .N_QUEUE(NQ), .DEPTH_LOG2(7), .DEST_MAX(DMAX), .REG_ADDR_WIDTH(AW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .reg_en(reg_en), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .done(done), .irq(irq)
    );

    always #5 aclk = ~aclk;

    // ---------------- behavioural model ----------------
    logic [63:0] mq [NQ][$];
    bit          mlv   [NQ];
    logic [31:0] mlow  [NQ];
    bit          merr  [NQ];
    int          mcnt  [NQ];
    bit          mmask [NQ];
    bit          exp_irq = 1'b0;
    logic [31:0] exp_rdata = '0;

    function automatic logic [63:0] san(input logic [63:0] c);
        logic [63:0] r;
        r = c;
        if (int'(r[2:0]) > DMAX) r[2:0] = 3'b000;
        return r;
    endfunction

    always @(posedge aclk or negedge aresetn) begin : model
        int q;
        int off;
        bit hit;
        bit wr;
        bit fullp;
        bit nirq;
        int sz;
        if (!aresetn) begin
            for (int i = 0; i < NQ; i++) begin
                mq[i].delete();
                mlv[i] = 0; merr[i] = 0; mcnt[i] = 0; mmask[i] = 0;
            end
            exp_rdata = '0;
            exp_irq = 1'b0;
        end else begin
            q   = int'(reg_addr[6:4]);
            off = int'(reg_addr[3:2]);
            hit = (reg_addr[AW-1:7] == '0) && (q < NQ);
            nirq = 0;
            for (int i = 0; i < NQ; i++)
                if (mmask[i] && mcnt[i] != 0) nirq = 1;
            fullp = 0;
            if (reg_en) begin
                exp_rdata = '0;
                if (hit) begin
                    sz = mq[q].size();
                    case (off)
                        0: exp_rdata = 32'(sz);
                        1: exp_rdata = 32'(DEPTH - sz);
                        2: exp_rdata = 32'(mcnt[q]);
                        default: exp_rdata = {27'b0, mmask[q], mlv[q], merr[q],
                                              sz == DEPTH, sz == 0};
                    endcase
                end
            end
            if (hit) fullp = (mq[q].size() == DEPTH);
            wr = reg_en && (reg_we == 4'hF) && hit;
            for (int i = 0; i < NQ; i++)
                if (mq[i].size() != 0 && cmd_ready[i]) void'(mq[i].pop_front());
            for (int i = 0; i < NQ; i++) begin
                if (wr && off == 2 && q == i) mcnt[i] = done[i] ? 1 : 0;
                else if (done[i] && mcnt[i] < 65535) mcnt[i]++;
            end
            if (wr) begin
                case (off)
                    0: begin mlow[q] = reg_wdata; mlv[q] = 1; end
                    1: begin
                        if (mlv[q] && !fullp) mq[q].push_back({reg_wdata, mlow[q]});
                        else merr[q] = 1;
                        mlv[q] = 0;
                    end
                    2: ;
                    default: begin
                        if (reg_wdata[0]) begin mq[q].delete(); mlv[q] = 0; end
                        if (reg_wdata[1]) merr[q] = 0;
                        if (IRQ_EN) mmask[q] = reg_wdata[4];
                    end
                endcase
            end
            exp_irq = IRQ_EN ? nirq : 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge aclk) begin
        for (int i = 0; i < NQ; i++) begin
            chk($sformatf("cmd_valid%0d", i), 64'(cmd_valid[i]), 64'(mq[i].size() != 0));
            chk($sformatf("cmd_data%0d", i), cmd_data[64*i +: 64],
                (mq[i].size() != 0) ? san(mq[i][0]) : 64'd0);
        end
        chk("irq", 64'(irq), 64'(exp_irq));
        chk("reg_rdata", 64'(reg_rdata), 64'(exp_rdata));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic wr(input int q, input int off, input logic [31:0] d);
        reg_en = 1'b1; reg_we = 4'hF;
        reg_addr = AW'(q * 16 + off); reg_wdata = d;
        tick();
        reg_en = 1'b0; reg_we = 4'h0;
    endtask

    task automatic rd(input int addr, output logic [31:0] d);
        reg_en = 1'b1; reg_we = 4'h0; reg_addr = AW'(addr);
        tick();
        reg_en = 1'b0;
        d = reg_rdata;
    endtask

    initial begin
        logic [31:0] v;
        int op;
        int q;
        tick();
        chk("rst_valid", 64'(cmd_valid), 64'd0);
        chk("rst_rdata", 64'(reg_rdata), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        tick();
        aresetn = 1'b1;
        tick();

        wr(0, 0, 32'h0);
        wr(0, 4, 32'h0100_0000);
        chk("t1_valid", 64'(cmd_valid[0]), 64'd1);
        chk("t1_data", cmd_data[63:0], 64'h0100_0000_0000_0000);
        rd(16'h000, v); chk("t1_occ", 64'(v), 64'd1);
        rd(16'h004, v); chk("t1_free", 64'(v), 64'd127);
        cmd_ready[0] = 1'b1; tick(); cmd_ready[0] = 1'b0;
        chk("t1_popped", 64'(cmd_valid[0]), 64'd0);

        wr(0, 0, 32'hABCD_EF45);
        wr(0, 4, 32'h1234_5678);
        chk("dest5", cmd_data[63:0], 64'h1234_5678_ABCD_EF40);
        cmd_ready[0] = 1'b1; tick(); cmd_ready[0] = 1'b0;
        wr(0, 0, 32'hABCD_EF43);
        wr(0, 4, 32'h0);
        chk("dest3", cmd_data[63:0], 64'h0000_0000_ABCD_EF43);
        cmd_ready[0] = 1'b1; tick(); cmd_ready[0] = 1'b0;

        for (int i = 0; i < 128; i++) begin
            wr(1, 0, 32'hC0DE_0000 | (i << 6));
            wr(1, 4, 32'(i));
        end
        rd(16'h010, v); chk("fill_occ", 64'(v), 64'd128);
        wr(1, 0, 32'h0);
        wr(1, 4, 32'hDEAD);
        rd(16'h01C, v); chk("ovf_status", 64'(v), 64'h6);
        rd(16'h014, v); chk("ovf_free", 64'(v), 64'd0);
        chk("ovf_head", cmd_data[127:64], 64'h0000_0000_C0DE_0000);
        wr(1, 12, 32'h2);
        rd(16'h01C, v); chk("err_clr", 64'(v), 64'h2);
        wr(1, 12, 32'h1);
        rd(16'h01C, v); chk("q1_flush", 64'(v), 64'h1);

        wr(0, 4, 32'h5555);
        rd(16'h00C, v); chk("orphan_hi", 64'(v), 64'h5);
        wr(0, 12, 32'h2);
        wr(0, 0, 32'h1111_1111);
        wr(0, 0, 32'h2222_2201);
        wr(0, 4, 32'h3333_3333);
        chk("relow", cmd_data[63:0], 64'h3333_3333_2222_2201);
        rd(16'h000, v); chk("relow_occ", 64'(v), 64'd1);

        for (int i = 0; i < 4; i++) begin
            wr(0, 0, 32'(i << 6));
            wr(0, 4, 32'(i));
        end
        rd(16'h000, v); chk("pre_flush", 64'(v), 64'd5);
        cmd_ready[0] = 1'b1;
        wr(0, 12, 32'h1);
        cmd_ready[0] = 1'b0;
        chk("flush_valid", 64'(cmd_valid[0]), 64'd0);
        rd(16'h00C, v); chk("flush_status", 64'(v), 64'h1);

        wr(0, 8, 32'h0);
        wr(0, 12, 32'h10);
        rd(16'h00C, v); chk("mask_rd", 64'(v), IRQ_EN ? 64'h11 : 64'h01);
        for (int k = 0; k < 3; k++) begin
            done[0] = 1'b1; tick(); done[0] = 1'b0; tick();
        end
        rd(16'h008, v); chk("cnt3", 64'(v), 64'd3);
        chk("irq_on", 64'(irq), 64'(IRQ_EN));
        done[0] = 1'b1;
        wr(0, 8, 32'h0);
        done[0] = 1'b0;
        rd(16'h008, v); chk("cnt_clr_done", 64'(v), 64'd1);
        chk("irq_hold", 64'(irq), 64'(IRQ_EN));
        wr(0, 8, 32'h0);
        tick();
        chk("irq_off", 64'(irq), 64'd0);
        rd(16'h008, v); chk("cnt0", 64'(v), 64'd0);

        wr(2, 0, 32'hFFFF_FFFF);
        rd(16'h020, v); chk("bad_q", 64'(v), 64'd0);
        rd(16'h10C, v); chk("bad_hi", 64'(v), 64'd0);

        for (int n = 0; n < 3000; n++) begin
            op = int'($urandom_range(0, 15));
            q = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, 1))
                                           : int'($urandom_range(2, 7));
            cmd_ready = NQ'($urandom);
            done = ($urandom_range(0, 3) == 0) ? NQ'($urandom) : '0;
            reg_en = 1'b1;
            reg_we = 4'hF;
            reg_wdata = $urandom;
            if (op < 5) reg_addr = AW'(q * 16);
            else if (op < 10) reg_addr = AW'(q * 16 + 4);
            else if (op == 10) reg_addr = AW'(q * 16 + 8);
            else if (op == 11) begin
                reg_addr = AW'(q * 16 + 12);
                reg_wdata[0] = ($urandom_range(0, 7) == 0);
            end else begin
                reg_we = 4'h0;
                reg_addr = ($urandom_range(0, 7) == 0) ? AW'($urandom)
                                                       : AW'(q * 16 + 4 * (op - 12));
            end
            if ($urandom_range(0, 15) == 0) reg_we = 4'($urandom);
            tick();
            reg_en = 1'b0; reg_we = 4'h0;
            cmd_ready = '0; done = '0;
        end

        wr(0, 0, 32'h7);
        wr(0, 4, 32'h9);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(cmd_valid), 64'd0);
        chk("mid_rst_data", cmd_data[63:0], 64'd0);
        chk("mid_rst_rdata", 64'(reg_rdata), 64'd0);
        chk("mid_rst_irq", 64'(irq), 64'd0);
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        rd(16'h00C, v); chk("post_rst_status", 64'(v), 64'h1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
